// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage: PC, IF/ID register, stall/redirect/halt
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 80,
    parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_ins,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
    localparam logic [0:0]  FETCH   = 1'b0;
    localparam logic [0:0]  HALT    = 1'b1;

    logic [31:0] pc;
    logic [0:0]  state;
    logic        in_range;

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign in_range  = (pc <= LAST_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0;
            if_id_ins   <= NOP_INS;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0;
            state       <= FETCH;
        end else if (redirect) begin
            // Target range is only checked on the following fetch edge.
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_pc    <= 32'h0;
            if_id_ins   <= NOP_INS;
            if_id_valid <= 1'b0;
            state       <= FETCH;
        end else if (state == HALT) begin
            if_id_pc    <= 32'h0;
            if_id_ins   <= NOP_INS;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
        end else if (in_range) begin
            if_id_pc    <= pc;
            if_id_ins   <= imem_ins;
            if_id_valid <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
        end else begin
            if_id_pc    <= 32'h0;
            if_id_ins   <= NOP_INS;
            if_id_valid <= 1'b0;
            state       <= HALT;
        end
    end

endmodule
